// File: rtl/debug_dump_pkg.sv
// Shared types and constants for the debug dump sequencer.
package debug_dump_pkg;

  // Top-level sequencing states of the dump walk.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_ISSUE,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
  } dump_state_e;

  // Memory window currently being walked.
  typedef enum logic [1:0] {
    SEC_REG,
    SEC_DMEM,
    SEC_IMEM
  } dump_section_e;

  // First byte of every dump, lets the receiver resynchronise.
  localparam logic [7:0] DUMP_HEADER = 8'hA5;

  // Number of bytes in one complete dump, header included.
  function automatic int unsigned dump_total_bytes(input int unsigned num_regs,
                                                   input int unsigned dmem_depth,
                                                   input int unsigned imem_depth,
                                                   input int unsigned inst_w);
    return 1 + num_regs + dmem_depth + imem_depth * (inst_w / 8);
  endfunction

endpackage

// File: rtl/debug_dump_sequencer.sv
// Freezes the core through its debug port, walks the register file, a dmem
// window and an imem window, and serialises the contents as a byte stream.
module debug_dump_sequencer
  import debug_dump_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int INST_W          = 16,
  parameter int D_ADDR_W        = 12,
  parameter int I_ADDR_W        = 12,
  parameter int REG_ADDR_WIDTH  = 4,
  parameter int NUM_DUMP_REGS   = 16,
  parameter int DMEM_DUMP_DEPTH = 16,
  parameter int IMEM_DUMP_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      dump_req,
  input  logic [D_ADDR_W-1:0]       dmem_base,
  input  logic [I_ADDR_W-1:0]       imem_base,
  output logic                      debug_enable,
  output logic [REG_ADDR_WIDTH-1:0] reg_debug_addr,
  output logic [D_ADDR_W-1:0]       dmem_debug_addr,
  output logic [I_ADDR_W-1:0]       imem_debug_addr,
  input  logic [DATA_W-1:0]         reg_debug_rdata,
  input  logic [DATA_W-1:0]         dmem_debug_rdata,
  input  logic [INST_W-1:0]         imem_debug_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic                      out_last,
  output logic                      busy
);

  localparam int BPI     = INST_W / 8;
  localparam int MAX_A   = (NUM_DUMP_REGS > DMEM_DUMP_DEPTH) ? NUM_DUMP_REGS : DMEM_DUMP_DEPTH;
  localparam int MAX_CNT = (MAX_A > IMEM_DUMP_DEPTH) ? MAX_A : IMEM_DUMP_DEPTH;
  localparam int IDX_W   = $clog2(MAX_CNT + 1);
  localparam int BYTE_W  = (BPI > 1) ? $clog2(BPI) : 1;

  // Empty sections never get compared against, so a wrapped -1 is harmless.
  localparam logic [IDX_W-1:0]  LAST_REG   = IDX_W'(NUM_DUMP_REGS - 1);
  localparam logic [IDX_W-1:0]  LAST_DMEM  = IDX_W'(DMEM_DUMP_DEPTH - 1);
  localparam logic [IDX_W-1:0]  LAST_IMEM  = IDX_W'(IMEM_DUMP_DEPTH - 1);
  localparam logic [BYTE_W-1:0] LAST_IBYTE = BYTE_W'(BPI - 1);
  localparam bit HAS_DMEM = (DMEM_DUMP_DEPTH > 0);
  localparam bit HAS_IMEM = (IMEM_DUMP_DEPTH > 0);

  dump_state_e               state_q, state_d;
  dump_section_e             sec_q, sec_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [BYTE_W-1:0]         byte_q, byte_d;
  logic [INST_W-1:0]         hold_q, hold_d;
  logic [D_ADDR_W-1:0]       dmem_base_q, dmem_base_d;
  logic [I_ADDR_W-1:0]       imem_base_q, imem_base_d;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [D_ADDR_W-1:0]       dmem_addr_q, dmem_addr_d;
  logic [I_ADDR_W-1:0]       imem_addr_q, imem_addr_d;

  logic          elem_last;
  logic          byte_last;
  logic          next_ok;
  dump_section_e next_sec;
  logic          go_issue;
  dump_section_e issue_sec;
  logic [IDX_W-1:0] issue_idx;

  // Instruction bytes, most significant first, so byte_q indexes send order.
  logic [7:0] inst_bytes [BPI];
  for (genvar gi = 0; gi < BPI; gi++) begin : g_inst_bytes
    assign inst_bytes[gi] = hold_q[INST_W-1-8*gi -: 8];
  end

  // Position within the current section and which section follows it.
  always_comb begin
    elem_last = 1'b0;
    byte_last = 1'b1;
    next_ok   = 1'b0;
    next_sec  = SEC_REG;
    unique case (sec_q)
      SEC_REG: begin
        elem_last = (idx_q == LAST_REG);
        if (HAS_DMEM) begin
          next_ok  = 1'b1;
          next_sec = SEC_DMEM;
        end else if (HAS_IMEM) begin
          next_ok  = 1'b1;
          next_sec = SEC_IMEM;
        end
      end
      SEC_DMEM: begin
        elem_last = (idx_q == LAST_DMEM);
        if (HAS_IMEM) begin
          next_ok  = 1'b1;
          next_sec = SEC_IMEM;
        end
      end
      SEC_IMEM: begin
        elem_last = (idx_q == LAST_IMEM);
        byte_last = (byte_q == LAST_IBYTE);
      end
      default: ;
    endcase
  end

  // Next-state logic; addresses are computed as we enter ISSUE so they are
  // already registered while ISSUE drives them.
  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    hold_d      = hold_q;
    dmem_base_d = dmem_base_q;
    imem_base_d = imem_base_q;
    reg_addr_d  = reg_addr_q;
    dmem_addr_d = dmem_addr_q;
    imem_addr_d = imem_addr_q;
    go_issue    = 1'b0;
    issue_sec   = sec_q;
    issue_idx   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          dmem_base_d = dmem_base;
          imem_base_d = imem_base;
          state_d     = ST_HEADER;
        end
      end
      ST_HEADER: begin
        // The register section always holds at least one entry.
        if (out_ready) begin
          go_issue  = 1'b1;
          issue_sec = SEC_REG;
        end
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        unique case (sec_q)
          SEC_DMEM: hold_d = INST_W'(dmem_debug_rdata);
          SEC_IMEM: hold_d = imem_debug_rdata;
          default:  hold_d = INST_W'(reg_debug_rdata);
        endcase
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          if (!byte_last) begin
            byte_d = byte_q + BYTE_W'(1);
          end else if (!elem_last) begin
            go_issue  = 1'b1;
            issue_idx = idx_q + IDX_W'(1);
          end else if (next_ok) begin
            go_issue  = 1'b1;
            issue_sec = next_sec;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (go_issue) begin
      state_d = ST_ISSUE;
      sec_d   = issue_sec;
      idx_d   = issue_idx;
      byte_d  = '0;
      unique case (issue_sec)
        SEC_DMEM: dmem_addr_d = dmem_base_q + D_ADDR_W'(issue_idx);
        SEC_IMEM: imem_addr_d = imem_base_q + I_ADDR_W'(issue_idx);
        default:  reg_addr_d  = REG_ADDR_WIDTH'(issue_idx);
      endcase
    end
  end

  // Output decode purely from registered state, so data/last hold under stall.
  always_comb begin
    debug_enable = (state_q == ST_HEADER) || (state_q == ST_ISSUE) ||
                   (state_q == ST_CAPTURE) || (state_q == ST_SEND);
    busy         = debug_enable;
    out_valid    = (state_q == ST_HEADER) || (state_q == ST_SEND);
    out_data     = 8'h00;
    out_last     = 1'b0;
    if (state_q == ST_HEADER) begin
      out_data = DUMP_HEADER;
    end else if (state_q == ST_SEND) begin
      out_data = (sec_q == SEC_IMEM) ? inst_bytes[byte_q] : hold_q[7:0];
      out_last = byte_last && elem_last && !next_ok;
    end
  end

  assign reg_debug_addr  = reg_addr_q;
  assign dmem_debug_addr = dmem_addr_q;
  assign imem_debug_addr = imem_addr_q;

  // State, counters and address registers; reset aborts any dump in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sec_q       <= SEC_REG;
      idx_q       <= '0;
      byte_q      <= '0;
      hold_q      <= '0;
      dmem_base_q <= '0;
      imem_base_q <= '0;
      reg_addr_q  <= '0;
      dmem_addr_q <= '0;
      imem_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      hold_q      <= hold_d;
      dmem_base_q <= dmem_base_d;
      imem_base_q <= imem_base_d;
      reg_addr_q  <= reg_addr_d;
      dmem_addr_q <= dmem_addr_d;
      imem_addr_q <= imem_addr_d;
    end
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Drives three sequencer instances (full, short wrapping dmem, registers only)
// against a stream model built from the memory contents and window bases.
module tb_debug_dump_sequencer;
  import debug_dump_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        dump_req;
  logic        out_ready;
  logic [11:0] dbase [3];
  logic [11:0] ibase [3];
  bit          mon_en;

  logic [7:0]  regs_m [16];
  logic [7:0]  dmem_m [4096];
  logic [15:0] imem_m [4096];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte k of a dump: header, registers, dmem window, imem window MSB first.
  function automatic logic [7:0] exp_byte(input int nd, input logic [11:0] db,
                                          input logic [11:0] ib, input int k);
    logic [15:0] w;
    int e;
    if (k == 0) return 8'hA5;
    if (k <= 16) return regs_m[k-1];
    if (k <= 16 + nd) return dmem_m[db + 12'(k - 17)];
    e = k - 17 - nd;
    w = imem_m[ib + 12'(e / 2)];
    return (e % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int ND    = (gi == 0) ? 16 : ((gi == 1) ? 4 : 0);
    localparam int NI    = (gi == 0) ? 16 : 0;
    localparam int TOTAL = int'(dump_total_bytes(16, ND, NI, 16));

    logic        debug_enable, out_valid, out_last, busy;
    logic [3:0]  reg_addr;
    logic [11:0] dmem_addr, imem_addr;
    logic [7:0]  reg_rd, dmem_rd, out_data;
    logic [15:0] imem_rd;

    debug_dump_sequencer #(
      .DMEM_DUMP_DEPTH(ND),
      .IMEM_DUMP_DEPTH(NI)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .dump_req(dump_req),
      .dmem_base(dbase[gi]), .imem_base(ibase[gi]),
      .debug_enable(debug_enable), .reg_debug_addr(reg_addr),
      .dmem_debug_addr(dmem_addr), .imem_debug_addr(imem_addr),
      .reg_debug_rdata(reg_rd), .dmem_debug_rdata(dmem_rd),
      .imem_debug_rdata(imem_rd), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    // Core memories with one cycle of read latency.
    always @(posedge clk) begin
      reg_rd  <= regs_m[reg_addr];
      dmem_rd <= dmem_m[dmem_addr];
      imem_rd <= imem_m[imem_addr];
    end

    int          cnt = 0;
    bit          stall = 0, chk_done = 0, prev_busy = 0;
    logic [7:0]  held_d;
    logic        held_l;
    logic [11:0] last_d = '0, last_i = '0, ea;

    always @(negedge clk) begin
      if (!reset_n) begin
        cnt = 0; stall = 0; chk_done = 0; prev_busy = 0;
        last_d = '0; last_i = '0;
      end else if (mon_en) begin
        if (busy && !prev_busy) cnt = 0;
        if (chk_done) begin
          check_eq($sformatf("i%0d_dbg_en_after_last", gi), 32'(debug_enable), 32'd0);
          check_eq($sformatf("i%0d_busy_after_last", gi), 32'(busy), 32'd0);
          chk_done = 0;
        end
        if (stall) begin
          check_eq($sformatf("i%0d_valid_held", gi), 32'(out_valid), 32'd1);
          check_eq($sformatf("i%0d_data_held", gi), 32'(out_data), 32'(held_d));
          check_eq($sformatf("i%0d_last_held", gi), 32'(out_last), 32'(held_l));
        end
        stall = 0;
        if (out_valid && out_ready) begin
          check_eq($sformatf("i%0d_byte%0d", gi, cnt), 32'(out_data),
                   32'(exp_byte(ND, dbase[gi], ibase[gi], cnt)));
          check_eq($sformatf("i%0d_last%0d", gi, cnt), 32'(out_last), 32'(cnt == TOTAL - 1));
          if (cnt >= 1 && cnt <= 16)
            check_eq($sformatf("i%0d_reg_addr", gi), 32'(reg_addr), 32'(cnt - 1));
          if (cnt > 16 && cnt <= 16 + ND) begin
            ea = dbase[gi] + 12'(cnt - 17);
            check_eq($sformatf("i%0d_dmem_addr", gi), 32'(dmem_addr), 32'(ea));
            last_d = ea;
          end else begin
            check_eq($sformatf("i%0d_dmem_addr_idle", gi), 32'(dmem_addr), 32'(last_d));
          end
          if (cnt > 16 + ND) begin
            ea = ibase[gi] + 12'((cnt - 17 - ND) / 2);
            check_eq($sformatf("i%0d_imem_addr", gi), 32'(imem_addr), 32'(ea));
            last_i = ea;
          end else begin
            check_eq($sformatf("i%0d_imem_addr_idle", gi), 32'(imem_addr), 32'(last_i));
          end
          cnt++;
          if (cnt == TOTAL) chk_done = 1;
        end else if (out_valid) begin
          stall = 1; held_d = out_data; held_l = out_last;
        end
        if (!busy && prev_busy)
          check_eq($sformatf("i%0d_byte_count", gi), 32'(cnt), 32'(TOTAL));
        prev_busy = busy;
      end
    end
  end

  function automatic logic any_busy();
    return g_inst[0].busy | g_inst[1].busy | g_inst[2].busy;
  endfunction

  task automatic randomize_mem();
    for (int i = 0; i < 16; i++) regs_m[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) begin
      dmem_m[i] = 8'($urandom);
      imem_m[i] = 16'($urandom);
    end
  endtask

  // One dump with a stray dump_req mid-stream; checks nothing follows it.
  task automatic run_dump(input bit rand_ready);
    bit done = 0, seen = 0;
    @(posedge clk); #1 dump_req = 1'b1;
    @(posedge clk); #1 dump_req = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      dump_req  = (c == 20);
      if (c > 2 && !any_busy()) done = 1;
    end
    dump_req  = 1'b0;
    out_ready = 1'b1;
    check_eq("dump_finished", 32'(done), 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (any_busy()) seen = 1;
    end
    check_eq("no_second_dump", 32'(seen), 32'd0);
  endtask

  initial begin
    bit hit = 0;
    reset_n = 1'b0; dump_req = 1'b0; out_ready = 1'b1; mon_en = 0;
    randomize_mem();
    for (int i = 0; i < 16; i++) regs_m[i] = 8'(i * 3);
    imem_m[0] = 16'h1234;
    dbase[0] = 12'h100; ibase[0] = 12'h000;
    dbase[1] = 12'hFFE; ibase[1] = 12'h000;
    dbase[2] = 12'h321; ibase[2] = 12'h456;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_dbg_en", 32'(g_inst[0].debug_enable), 32'd0);
    check_eq("rst_busy", 32'(g_inst[0].busy), 32'd0);
    check_eq("rst_valid", 32'(g_inst[0].out_valid), 32'd0);
    check_eq("rst_last", 32'(g_inst[0].out_last), 32'd0);
    check_eq("rst_addrs", 32'({g_inst[0].reg_addr, g_inst[0].dmem_addr, g_inst[0].imem_addr}), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1; mon_en = 1;

    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (g_inst[0].out_valid || any_busy()) hit = 1;
    end
    check_eq("idle_no_stream", 32'(hit), 32'd0);

    run_dump(1'b0);

    for (int d = 0; d < 3; d++) begin
      randomize_mem();
      dbase[0] = 12'($urandom); ibase[0] = 12'($urandom);
      dbase[1] = 12'hFFC + 12'($urandom_range(0, 3)); ibase[1] = 12'($urandom);
      dbase[2] = 12'($urandom); ibase[2] = 12'hFFF;
      run_dump(1'b1);
    end

    // Abort part-way through and restart from the header.
    @(posedge clk); #1 dump_req = 1'b1;
    @(posedge clk); #1 dump_req = 1'b0;
    hit = 0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge clk);
      if (g_inst[0].cnt >= 10) hit = 1;
    end
    check_eq("abort_reached_byte10", 32'(hit), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("abort_dbg_en", 32'(g_inst[0].debug_enable), 32'd0);
    check_eq("abort_busy", 32'(g_inst[0].busy), 32'd0);
    check_eq("abort_valid", 32'(g_inst[0].out_valid), 32'd0);
    check_eq("abort_data", 32'(g_inst[0].out_data), 32'd0);
    check_eq("abort_addrs", 32'({g_inst[0].reg_addr, g_inst[0].dmem_addr, g_inst[0].imem_addr}), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    run_dump(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_dump_sequencer.md
Name: debug_dump_sequencer

Overview:
- Sits beside turtle_cpu_subsystem and drives its debug port (debug_enable, reg/dmem/imem debug address and read-data).
- On a single dump request it freezes the core, walks register-file, data-memory and instruction-memory windows, and serialises the contents into a byte stream with a valid/ready handshake.
- The byte stream is consumed by a later UART/LED transmit stage.

Parameters:
- DATA_W, 8, data word width (register and dmem read-data).
- INST_W, 16, instruction width; must be a multiple of 8.
- D_ADDR_W, 12, dmem address width.
- I_ADDR_W, 12, imem address width.
- REG_ADDR_WIDTH, 4, register debug address width.
- NUM_DUMP_REGS, 16, registers dumped (1..2**REG_ADDR_WIDTH).
- DMEM_DUMP_DEPTH, 16, dmem words dumped (0 = section skipped).
- IMEM_DUMP_DEPTH, 16, imem words dumped (0 = section skipped).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- dump_req  in  1  start pulse, sampled in IDLE only
- dmem_base  in  D_ADDR_W  dmem window start, latched on accept
- imem_base  in  I_ADDR_W  imem window start, latched on accept
- debug_enable  out  1  freezes core / selects debug read path
- reg_debug_addr  out  REG_ADDR_WIDTH  register read address
- dmem_debug_addr  out  D_ADDR_W  dmem read address
- imem_debug_addr  out  I_ADDR_W  imem read address
- reg_debug_rdata  in  DATA_W  register read data
- dmem_debug_rdata  in  DATA_W  dmem read data
- imem_debug_rdata  in  INST_W  imem read data
- out_valid  out  1  stream byte valid
- out_ready  in  1  downstream ready
- out_data  out  8  stream byte
- out_last  out  1  final byte of dump
- busy  out  1  high from accept through final handshake

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0, including debug_enable, all addresses, out_valid, out_last and busy.
- Reset mid-dump aborts the dump. No partial completion; the next dump restarts at the header.
- FSM states: IDLE, HEADER, ISSUE, CAPTURE, SEND, DONE. Section register cycles REG -> DMEM -> IMEM. Counters: element index, byte index.
- IDLE:
  - dump_req=1 -> latch the bases; set debug_enable=1 and busy=1 the next cycle; go to HEADER.
  - dump_req while busy is ignored; it is not queued.
- HEADER:
  - out_valid=1, out_data=8'hA5.
  - Handshake -> ISSUE on the first non-empty section.
- ISSUE: drive the registered address for 1 cycle.
  - REG: index.
  - DMEM: dmem_base+index, modulo 2**D_ADDR_W (wraps).
  - IMEM: imem_base+index, modulo 2**I_ADDR_W (wraps).
  - Addresses stay stable through CAPTURE and SEND.
- CAPTURE:
  - Read data has a fixed 1-cycle latency. Sample the selected rdata into a holding register at the end of this cycle.
  - Next state is SEND.
- SEND:
  - out_valid=1.
  - REG/DMEM: 1 byte (low 8 bits of the holding register).
  - IMEM: INST_W/8 bytes, MSB byte first.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - A transfer occurs on out_valid && out_ready.
  - After the last byte of an element: next index, or next section with index reset to 0, then ISSUE.
  - If no element remains: DONE.
- out_last=1 only on the final byte of the final non-empty section.
- DONE (1 cycle): debug_enable=0, busy=0, out_valid=0; return to IDLE. dump_req is accepted again from IDLE on the following cycle.
- Best-case element cost: 3 cycles (ISSUE, CAPTURE, SEND with out_ready=1).
- Total bytes = 1 + NUM_DUMP_REGS + DMEM_DUMP_DEPTH + IMEM_DUMP_DEPTH*INST_W/8. At defaults this is 65.
- out_ready is ignored outside HEADER/SEND.

Decomposition:
- debug_dump_pkg holds:
  - the state enum (dump_state_e);
  - the section enum (dump_section_e);
  - the constant DUMP_HEADER = 8'hA5;
  - a function computing the total byte count for assertions.
- No sub-module: FSM, counters and output register fit in one module of about 200 lines.

Test Plan:
- Reset/idle: hold reset_n=0 for 5 cycles, then release. -> debug_enable, busy, out_valid and all addresses are 0. No stream while dump_req=0.
- Full dump with out_ready=1, default parameters, regs preloaded r=i*3, dmem_base=12'h100, imem_base=12'h000 holding 16'h1234 at 0. -> 65 bytes: A5, 00,03,...,2D, then 16 dmem bytes from 0x100..0x10F, then 12,34,... out_last only on byte 65; debug_enable falls 1 cycle after it.
- Backpressure: toggle out_ready randomly at 50%. -> same 65-byte sequence. out_data and out_last never change while out_valid && !out_ready.
- Wrap: dmem_base=12'hFFE, DMEM_DUMP_DEPTH=4. -> dmem_debug_addr sequence FFE, FFF, 000, 001.
- Empty sections: DMEM_DUMP_DEPTH=0, IMEM_DUMP_DEPTH=0. -> 17 bytes. out_last on the last register byte. dmem/imem addresses never leave 0.
- Abort/re-trigger: assert reset_n=0 after byte 10, release, pulse dump_req. -> outputs 0 immediately on reset. The new stream starts with A5 and register 0. A dump_req pulsed while busy produces no second dump.
